// File: rtl/gshare_ctrl.sv
// gshare_ctrl: forms the gshare index, predicts from the counter table,
// tracks in-flight predictions and writes back saturating updates.
module gshare_ctrl #(
   parameter int width = 2,
   parameter int HIST  = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pred_valid,
   input  logic [31:0]            pred_pc,
   output logic                   pred_ready,
   output logic                   pred_taken,
   output logic [HIST-1:0]        tbl_index,
   input  logic [width-1:0]       tbl_rdata,
   input  logic                   res_valid,
   input  logic                   res_taken,
   output logic                   res_mispredict,
   output logic                   tbl_write,
   output logic [HIST-1:0]        tbl_write_idx,
   output logic [width-1:0]       tbl_wdata,
   output logic [$clog2(DEPTH):0] inflight
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [width-1:0] CMAX = {width{1'b1}};

   logic [HIST-1:0]  ghr;
   logic [HIST-1:0]  q_idx  [DEPTH];
   logic [width-1:0] q_ctr  [DEPTH];
   logic             q_prd  [DEPTH];
   logic [HIST-1:0]  q_ckpt [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             full;
   logic             accept;
   logic             pop;
   logic             mispred;
   logic [width-1:0] old_ctr;
   logic [width-1:0] new_ctr;

   assign full       = (count == (PW+1)'(DEPTH));
   assign pred_ready = !full;
   assign tbl_index  = pred_pc[HIST+1:2] ^ ghr;
   assign pred_taken = tbl_rdata[width-1];
   assign accept     = pred_valid && !full;
   assign pop        = res_valid && (count != '0);
   assign old_ctr    = q_ctr[rd_ptr];
   assign mispred    = pop && (res_taken != q_prd[rd_ptr]);
   assign inflight   = count;

   // saturating counter update from the stored (possibly stale) value
   always_comb begin
      new_ctr = old_ctr;
      if (res_taken) begin
         if (old_ctr != CMAX) new_ctr = old_ctr + 1'b1;
      end else begin
         if (old_ctr != '0) new_ctr = old_ctr - 1'b1;
      end
   end

   // GHR and FIFO pointers; a mispredict flushes and drops same-cycle accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (mispred) begin
         ghr    <= {q_ckpt[rd_ptr][HIST-2:0], res_taken};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            ghr    <= {ghr[HIST-2:0], pred_taken};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (accept && !pop) count <= count + 1'b1;
         else if (pop && !accept) count <= count - 1'b1;
      end
   end

   // in-flight entry storage; pointers alone define validity
   always_ff @(posedge clk) begin
      if (accept) begin
         q_idx[wr_ptr]  <= tbl_index;
         q_ctr[wr_ptr]  <= tbl_rdata;
         q_prd[wr_ptr]  <= pred_taken;
         q_ckpt[wr_ptr] <= ghr;
      end
   end

   // registered table write-back and mispredict pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_write      <= 1'b0;
         tbl_write_idx  <= '0;
         tbl_wdata      <= '0;
         res_mispredict <= 1'b0;
      end else begin
         tbl_write      <= pop;
         res_mispredict <= mispred;
         if (pop) begin
            tbl_write_idx <= q_idx[rd_ptr];
            tbl_wdata     <= new_ctr;
         end
      end
   end

endmodule

// File: tb/tb_gshare_ctrl.sv
// tb_gshare_ctrl: scoreboard bench for gshare_ctrl with a
// behavioural 256x2 counter table attached.
module tb_gshare_ctrl;

   typedef struct {
      logic [7:0] idx;
      logic [1:0] c;
      logic       p;
      logic [7:0] ck;
   } ent_t;

   typedef struct {
      logic [7:0] idx;
      logic [1:0] d;
      logic       m;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_ready;
   logic        pred_taken;
   logic [7:0]  tbl_index;
   logic [1:0]  tbl_rdata;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispredict;
   logic        tbl_write;
   logic [7:0]  tbl_write_idx;
   logic [1:0]  tbl_wdata;
   logic [2:0]  inflight;

   logic [1:0] tbl [256];
   logic       tb_init;
   logic       pre_wr;
   logic [7:0] pre_idx;
   logic [1:0] pre_val;

   logic [7:0] mghr;
   ent_t       mq[$];
   wr_t        wq[$];
   int         vecs = 0;
   int         errs = 0;

   gshare_ctrl #(.width(2), .HIST(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_ready(pred_ready), .pred_taken(pred_taken),
      .tbl_index(tbl_index), .tbl_rdata(tbl_rdata),
      .res_valid(res_valid), .res_taken(res_taken),
      .res_mispredict(res_mispredict), .tbl_write(tbl_write),
      .tbl_write_idx(tbl_write_idx), .tbl_wdata(tbl_wdata),
      .inflight(inflight)
   );

   always #5 clk = ~clk;

   // the counter table: init pattern, DUT write port, bench preload
   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) tbl[i] <= 2'(i);
      end else if (tbl_write) begin
         tbl[tbl_write_idx] <= tbl_wdata;
      end else if (pre_wr) begin
         tbl[pre_idx] <= pre_val;
      end
   end

   assign tbl_rdata = tbl[tbl_index];

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout want finish");
      $fatal(1);
   end

   task automatic set_in(input logic pv, input logic [31:0] pc,
                         input logic rv, input logic rt);
      @(negedge clk);
      pred_valid = pv;
      pred_pc    = pc;
      res_valid  = rv;
      res_taken  = rt;
      #1;
   endtask

   task automatic commit();
      ent_t e;
      wr_t  w;
      logic acc, pp, mis;
      logic [7:0] ix;
      logic [1:0] c;
      ix  = pred_pc[9:2] ^ mghr;
      c   = tbl[ix];
      acc = pred_valid && (mq.size() < 4);
      pp  = res_valid && (mq.size() != 0);
      mis = 1'b0;
      if (pp) begin
         e     = mq.pop_front();
         w.idx = e.idx;
         w.m   = (res_taken != e.p);
         mis   = w.m;
         if (res_taken) w.d = (e.c == 2'd3) ? 2'd3 : 2'(e.c + 2'd1);
         else           w.d = (e.c == 2'd0) ? 2'd0 : 2'(e.c - 2'd1);
         wq.push_back(w);
      end
      if (mis) begin
         mq.delete();
         mghr = {e.ck[6:0], res_taken};
      end else if (acc) begin
         e.idx = ix;
         e.c   = c;
         e.p   = c[1];
         e.ck  = mghr;
         mq.push_back(e);
         mghr = {mghr[6:0], c[1]};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] ix, input logic [1:0] v);
      pre_idx = ix;
      pre_val = v;
      pre_wr  = 1'b1;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      commit();
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      commit();
      pre_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tb_init = 1'b1; pre_wr = 1'b0;
      pre_idx = '0; pre_val = '0;
      pred_valid = 1'b0; pred_pc = '0;
      res_valid = 1'b0; res_taken = 1'b0;
      mghr = '0;
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (pred_ready !== 1'b1) begin errs++;
         $display("FAIL rst_ready: got %b want 1", pred_ready); end
      vecs++; if (inflight !== 3'd0) begin errs++;
         $display("FAIL rst_inflight: got %0d want 0", inflight); end
      vecs++; if (tbl_write !== 1'b0) begin errs++;
         $display("FAIL rst_write: got %b want 0", tbl_write); end
      vecs++; if (tbl_write_idx !== 8'h00) begin errs++;
         $display("FAIL rst_widx: got %h want 00", tbl_write_idx); end
      vecs++; if (tbl_wdata !== 2'd0) begin errs++;
         $display("FAIL rst_wdata: got %0d want 0", tbl_wdata); end
      vecs++; if (res_mispredict !== 1'b0) begin errs++;
         $display("FAIL rst_misp: got %b want 0", res_mispredict); end
      vecs++; if (tbl_index !== 8'h00) begin errs++;
         $display("FAIL rst_ghr: got %h want 00", tbl_index); end
      @(negedge clk);
      rst_n = 1'b1;
      tb_init = 1'b0;
   endtask

   task automatic test_basic();
      wr_t w;
      set_in(1'b1, 32'h10, 1'b0, 1'b0);
      vecs++; if (tbl_index !== 8'h04) begin errs++;
         $display("FAIL basic_idx: got %h want 04", tbl_index); end
      vecs++; if (pred_taken !== 1'b0) begin errs++;
         $display("FAIL basic_pred: got %b want 0", pred_taken); end
      commit();
      vecs++; if (inflight !== 3'd1) begin errs++;
         $display("FAIL basic_inflight: got %0d want 1", inflight); end
      set_in(1'b0, 32'h0, 1'b1, 1'b1);
      vecs++; if (tbl_index !== 8'h00) begin errs++;
         $display("FAIL basic_ghr0: got %h want 00", tbl_index); end
      commit();
      w = wq.pop_front();
      vecs++;
      if (tbl_write !== 1'b1 || tbl_write_idx !== w.idx ||
          tbl_wdata !== w.d || res_mispredict !== w.m) begin errs++;
         $display("FAIL basic_wr: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                  tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                  w.idx, w.d, w.m); end
      vecs++;
      if ({tbl_write_idx, tbl_wdata, res_mispredict} !== {8'h04, 2'd1, 1'b1}) begin
         errs++;
         $display("FAIL basic_const: got %h/%0d/%b want 04/1/1",
                  tbl_write_idx, tbl_wdata, res_mispredict); end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      vecs++; if (tbl_index !== 8'h01) begin errs++;
         $display("FAIL basic_ghr1: got %h want 01", tbl_index); end
      commit();
      vecs++; if (tbl_write !== 1'b0 || res_mispredict !== 1'b0) begin errs++;
         $display("FAIL basic_pulse: got %b/%b want 0/0",
                  tbl_write, res_mispredict); end
   endtask

   task automatic test_saturation();
      logic [1:0] st [3]  = '{2'd3, 2'd0, 2'd2};
      logic       rt [3]  = '{1'b1, 1'b0, 1'b0};
      logic [1:0] ed [3]  = '{2'd3, 2'd0, 2'd1};
      logic       em [3]  = '{1'b0, 1'b0, 1'b1};
      logic [31:0] pc;
      logic [7:0]  ix;
      wr_t w;
      for (int k = 0; k < 3; k++) begin
         pc = 32'(32'h100 + k * 16);
         ix = pc[9:2] ^ mghr;
         poke(ix, st[k]);
         set_in(1'b1, pc, 1'b0, 1'b0);
         vecs++; if (pred_taken !== st[k][1]) begin errs++;
            $display("FAIL sat_pred%0d: got %b want %b", k, pred_taken, st[k][1]); end
         commit();
         set_in(1'b0, 32'h0, 1'b1, rt[k]);
         commit();
         w = wq.pop_front();
         vecs++;
         if (tbl_write !== 1'b1 || tbl_write_idx !== ix || tbl_wdata !== ed[k] ||
             res_mispredict !== em[k] || tbl_wdata !== w.d) begin errs++;
            $display("FAIL sat_wr%0d: got %b/%h/%0d/%b want 1/%h/%0d/%b", k,
                     tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                     ix, ed[k], em[k]); end
      end
   endtask

   task automatic test_full();
      logic [7:0] g;
      wr_t w;
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 32'(32'h200 + k * 4), 1'b0, 1'b0);
         commit();
      end
      vecs++; if (inflight !== 3'd4) begin errs++;
         $display("FAIL full_inflight: got %0d want 4", inflight); end
      vecs++; if (pred_ready !== 1'b0) begin errs++;
         $display("FAIL full_ready: got %b want 0", pred_ready); end
      g = mghr;
      set_in(1'b1, 32'h0, 1'b0, 1'b0);
      vecs++; if (tbl_index !== g) begin errs++;
         $display("FAIL full_ghr: got %h want %h", tbl_index, g); end
      commit();
      vecs++; if (inflight !== 3'd4) begin errs++;
         $display("FAIL full_fifth: got %0d want 4", inflight); end
      set_in(1'b0, 32'h0, 1'b1, mq[0].p);
      commit();
      w = wq.pop_front();
      vecs++;
      if (tbl_write !== 1'b1 || tbl_write_idx !== w.idx ||
          tbl_wdata !== w.d || res_mispredict !== 1'b0) begin errs++;
         $display("FAIL full_wr: got %b/%h/%0d/%b want 1/%h/%0d/0",
                  tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                  w.idx, w.d); end
      vecs++; if (inflight !== 3'd3 || pred_ready !== 1'b1) begin errs++;
         $display("FAIL full_pop: got %0d/%b want 3/1", inflight, pred_ready); end
   endtask

   task automatic test_flush();
      logic [7:0] ck;
      logic       rt;
      wr_t w;
      ck = mq[0].ck;
      rt = !mq[0].p;
      set_in(1'b1, 32'h300, 1'b1, rt);
      commit();
      w = wq.pop_front();
      vecs++;
      if (tbl_write !== 1'b1 || tbl_write_idx !== w.idx ||
          tbl_wdata !== w.d || res_mispredict !== 1'b1) begin errs++;
         $display("FAIL flush_wr: got %b/%h/%0d/%b want 1/%h/%0d/1",
                  tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                  w.idx, w.d); end
      vecs++; if (inflight !== 3'd0) begin errs++;
         $display("FAIL flush_inflight: got %0d want 0", inflight); end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      vecs++; if (tbl_index !== {ck[6:0], rt}) begin errs++;
         $display("FAIL flush_ghr: got %h want %h", tbl_index, {ck[6:0], rt}); end
      commit();
      vecs++; if (tbl_write !== 1'b0 || res_mispredict !== 1'b0) begin errs++;
         $display("FAIL flush_pulse: got %b/%b want 0/0",
                  tbl_write, res_mispredict); end
   endtask

   task automatic test_empty_resolve();
      logic [7:0] g;
      g = mghr;
      set_in(1'b0, 32'h0, 1'b1, 1'b1);
      commit();
      vecs++; if (tbl_write !== 1'b0 || res_mispredict !== 1'b0) begin errs++;
         $display("FAIL empty_wr: got %b/%b want 0/0", tbl_write, res_mispredict); end
      vecs++; if (inflight !== 3'd0) begin errs++;
         $display("FAIL empty_inflight: got %0d want 0", inflight); end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      vecs++; if (tbl_index !== g) begin errs++;
         $display("FAIL empty_ghr: got %h want %h", tbl_index, g); end
      commit();
   endtask

   task automatic test_back_to_back();
      wr_t w;
      int  n;
      set_in(1'b1, 32'h40, 1'b0, 1'b0);
      commit();
      set_in(1'b1, 32'h44, 1'b0, 1'b0);
      commit();
      for (int k = 0; k < 2; k++) begin
         set_in(1'b1, 32'(32'h48 + k * 4), 1'b1, mq[0].p);
         commit();
         w = wq.pop_front();
         vecs++;
         if (tbl_write !== 1'b1 || tbl_write_idx !== w.idx ||
             tbl_wdata !== w.d || res_mispredict !== 1'b0) begin errs++;
            $display("FAIL b2b_wr%0d: got %b/%h/%0d/%b want 1/%h/%0d/0", k,
                     tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                     w.idx, w.d); end
         vecs++; if (inflight !== 3'd2) begin errs++;
            $display("FAIL b2b_inflight%0d: got %0d want 2", k, inflight); end
      end
      n = 0;
      while (mq.size() != 0 && n < 8) begin
         set_in(1'b0, 32'h0, 1'b1, mq[0].p);
         commit();
         w = wq.pop_front();
         vecs++;
         if (tbl_write !== 1'b1 || tbl_write_idx !== w.idx ||
             tbl_wdata !== w.d || res_mispredict !== 1'b0) begin errs++;
            $display("FAIL b2b_drain%0d: got %b/%h/%0d/%b want 1/%h/%0d/0", n,
                     tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                     w.idx, w.d); end
         n++;
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      vecs++; if (inflight !== 3'd0 || tbl_index !== mghr) begin errs++;
         $display("FAIL b2b_end: got %0d/%h want 0/%h", inflight, tbl_index, mghr); end
      commit();
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] ix;
      logic [1:0] old;
      logic       rt;
      wr_t w;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      commit();
      set_in(1'b1, 32'h80, 1'b0, 1'b0);
      commit();
      ix  = mq[0].idx;
      rt  = (mq[0].c != 2'd3);
      set_in(1'b0, 32'h0, 1'b1, rt);
      commit();
      old = tbl[ix];
      w = wq.pop_front();
      vecs++; if (tbl_write !== 1'b1 || tbl_wdata !== w.d) begin errs++;
         $display("FAIL rmw_pre: got %b/%0d want 1/%0d", tbl_write, tbl_wdata, w.d); end
      #2;
      rst_n = 1'b0;
      #1;
      vecs++;
      if (tbl_write !== 1'b0 || tbl_write_idx !== 8'h00 || tbl_wdata !== 2'd0 ||
          res_mispredict !== 1'b0 || inflight !== 3'd0 || pred_ready !== 1'b1) begin
         errs++;
         $display("FAIL rmw_rst: got %b/%h/%0d/%b/%0d/%b want 0/00/0/0/0/1",
                  tbl_write, tbl_write_idx, tbl_wdata, res_mispredict,
                  inflight, pred_ready); end
      res_valid = 1'b0;
      mq.delete();
      mghr = '0;
      @(posedge clk);
      #1;
      vecs++; if (tbl[ix] !== old) begin errs++;
         $display("FAIL rmw_tbl: got %0d want %0d", tbl[ix], old); end
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      vecs++; if (tbl_index !== 8'h00) begin errs++;
         $display("FAIL rmw_ghr: got %h want 00", tbl_index); end
      commit();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_full();
      test_flush();
      test_empty_resolve();
      test_back_to_back();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
